// File: rtl/priority_encoder_8.sv
// Registered 8-to-3 priority encoder with edge-captured, acknowledged requests.
// Define PRIO_ENC_LEVEL_EN for level mode (pend follows the synchronized lines directly).
module priority_encoder_8 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ei_n,
    input  logic [7:0] i_n,
    input  logic       ack,
    output logic [2:0] a_n,
    output logic       gs_n,
    output logic       eo_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    state_t     state, state_next;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_last;
    logic [7:0] pend;
    logic [2:0] a_n_next;
    logic       gs_n_next;
    logic       busy_next;
    logic       eo_n_next;

    assign sync_last = sync_q[SYNC_STAGES-1];

    function automatic logic [2:0] highest(input logic [7:0] v);
        highest = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (v[k]) highest = k[2:0];
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
        end else begin
            sync_q[0] <= i_n;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef PRIO_ENC_LEVEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= ~sync_last;
    end
`else
    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;

    logic [2:0] warm;
    logic       armed;
    logic [7:0] sync_dly;
    logic [7:0] fall_q;
    logic [7:0] clr;
    logic [2:0] pres_idx;

    // Edges are ignored until the chain and sync_dly hold only post-reset samples,
    // so a line held low through reset does not look like a fresh request.
    assign armed    = (warm == 3'(WARM_MAX));
    assign pres_idx = ~a_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm     <= '0;
            sync_dly <= '1;
            fall_q   <= '0;
            pend     <= '0;
        end else begin
            sync_dly <= sync_last;
            fall_q   <= armed ? (sync_dly & ~sync_last) : '0;
            if (!armed) warm <= warm + 3'd1;
            pend     <= (pend & ~clr) | fall_q;
        end
    end
`endif

    always_comb begin
        state_next = state;
        a_n_next   = a_n;
        gs_n_next  = gs_n;
        busy_next  = busy;
`ifndef PRIO_ENC_LEVEL_EN
        clr        = '0;
`endif
        case (state)
            IDLE: begin
                if (!ei_n && (pend != '0)) begin
                    a_n_next   = ~highest(pend);
                    gs_n_next  = 1'b0;
                    busy_next  = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
`ifndef PRIO_ENC_LEVEL_EN
                    clr[pres_idx] = 1'b1;
`endif
                    a_n_next   = '1;
                    gs_n_next  = 1'b1;
                    state_next = GAP;
                end else if (ei_n) begin
                    a_n_next   = '1;
                    gs_n_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            GAP: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                a_n_next   = '1;
                gs_n_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
        eo_n_next = ~(~ei_n & (state == IDLE) & (pend == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_n   <= '1;
            gs_n  <= 1'b1;
            busy  <= 1'b0;
            eo_n  <= 1'b1;
        end else begin
            state <= state_next;
            a_n   <= a_n_next;
            gs_n  <= gs_n_next;
            busy  <= busy_next;
            eo_n  <= eo_n_next;
        end
    end

endmodule
